// File: rtl/oven_pkg.sv
// Shared types and defaults for the oven controller slice.
package oven_pkg;

    // 10-bit unsigned temperature / time quantity
    typedef logic [9:0] word_t;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPreheat = 2'd1,
        StBake    = 2'd2,
        StDone    = 2'd3
    } oven_state_e;

    localparam int unsigned TempMinDefault = 300;
    localparam int unsigned TempMaxDefault = 500;
    localparam int unsigned AmbientDefault = 70;

    // Limit a requested setpoint to the accepted range
    function automatic word_t clamp_temp(word_t t, word_t lo, word_t hi);
        if (t < lo) begin
            return lo;
        end else if (t > hi) begin
            return hi;
        end
        return t;
    endfunction

endpackage

// File: rtl/oven_controller_if.sv
// Entry-path inputs and display/LED outputs of the oven controller.
interface oven_controller_if;
    import oven_pkg::*;

    logic        onOff;
    logic        start;
    logic        cancel;
    word_t       temp;
    word_t       timer;
    word_t       cur_temp;
    word_t       time_left;
    word_t       set_temp;
    logic        heater;
    logic        alarm;
    logic [1:0]  state_o;

    modport master (
        output onOff, start, cancel, temp, timer,
        input  cur_temp, time_left, set_temp, heater, alarm, state_o
    );

    modport slave (
        input  onOff, start, cancel, temp, timer,
        output cur_temp, time_left, set_temp, heater, alarm, state_o
    );

endinterface

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
module tick_gen #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic reset,
    output logic tick_o
);

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CntMax);

    // Wrap to zero on the tick cycle, otherwise count up
    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + CntW'(1);
    end

    // Counter register, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/oven_controller.sv
// Simulated oven: preheat ramp, timed bake, done alarm and passive cooling.
module oven_controller
    import oven_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 50000000,
    parameter int unsigned RAMP_STEP   = 50,
    parameter int unsigned AMBIENT     = AmbientDefault,
    parameter int unsigned TEMP_MIN    = TempMinDefault,
    parameter int unsigned TEMP_MAX    = TempMaxDefault,
    parameter int unsigned ALARM_TICKS = 3
) (
    input  logic               clk,
    input  logic               reset,
    oven_controller_if.slave   bus
);

    localparam word_t Ambient  = word_t'(AMBIENT);
    localparam word_t RampStep = word_t'(RAMP_STEP);
    localparam word_t TempMin  = word_t'(TEMP_MIN);
    localparam word_t TempMax  = word_t'(TEMP_MAX);
    localparam int unsigned AcntW = (ALARM_TICKS > 0) ? $clog2(ALARM_TICKS + 1) : 1;

    logic tick;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .tick_o (tick)
    );

    oven_state_e      state_q, state_d;
    word_t            cur_temp_q, cur_temp_d;
    word_t            time_left_q, time_left_d;
    word_t            set_temp_q, set_temp_d;
    logic             heater_q, heater_d;
    logic             alarm_q, alarm_d;
    logic [AcntW-1:0] acnt_q, acnt_d;

    logic        abort;
    logic [10:0] heat_sum;
    word_t       heat_next;
    word_t       cool_next;

    assign abort = !bus.onOff || bus.cancel;

    // Ramp add is done in 11 bits so the setpoint compare can never see a wrapped value
    assign heat_sum  = {1'b0, cur_temp_q} + 11'(RAMP_STEP);
    assign heat_next = (heat_sum >= {1'b0, set_temp_q}) ? set_temp_q : heat_sum[9:0];
    assign cool_next = ({1'b0, cur_temp_q} >= 11'(AMBIENT + RAMP_STEP)) ?
                       (cur_temp_q - RampStep) : Ambient;

    // Next-state and next-output computation
    always_comb begin
        state_d     = state_q;
        cur_temp_d  = cur_temp_q;
        time_left_d = time_left_q;
        set_temp_d  = set_temp_q;
        acnt_d      = acnt_q;

        if (state_q != StIdle && abort) begin
            // Abort keeps the current temperature; it cools from there in IDLE
            state_d     = StIdle;
            time_left_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (tick) begin
                        cur_temp_d = cool_next;
                    end
                    if (bus.start && !abort && (bus.timer != '0)) begin
                        set_temp_d  = clamp_temp(bus.temp, TempMin, TempMax);
                        time_left_d = bus.timer;
                        state_d     = StPreheat;
                    end
                end
                StPreheat: begin
                    if (cur_temp_q >= set_temp_q) begin
                        cur_temp_d = set_temp_q;
                        state_d    = StBake;
                    end else if (tick) begin
                        cur_temp_d = heat_next;
                    end
                end
                StBake: begin
                    if (tick) begin
                        time_left_d = time_left_q - word_t'(1);
                        if (time_left_q <= word_t'(1)) begin
                            time_left_d = '0;
                            acnt_d      = AcntW'(ALARM_TICKS);
                            state_d     = StDone;
                        end
                    end
                end
                StDone: begin
                    if (tick) begin
                        cur_temp_d = cool_next;
                        acnt_d     = acnt_q - AcntW'(1);
                        if (acnt_q <= AcntW'(1)) begin
                            acnt_d  = '0;
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        heater_d = (state_d == StPreheat) || (state_d == StBake);
        alarm_d  = (state_d == StDone);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cur_temp_q  <= Ambient;
            time_left_q <= '0;
            set_temp_q  <= TempMin;
            heater_q    <= 1'b0;
            alarm_q     <= 1'b0;
            acnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            cur_temp_q  <= cur_temp_d;
            time_left_q <= time_left_d;
            set_temp_q  <= set_temp_d;
            heater_q    <= heater_d;
            alarm_q     <= alarm_d;
            acnt_q      <= acnt_d;
        end
    end

    assign bus.cur_temp  = cur_temp_q;
    assign bus.time_left = time_left_q;
    assign bus.set_temp  = set_temp_q;
    assign bus.heater    = heater_q;
    assign bus.alarm     = alarm_q;
    assign bus.state_o   = state_q;

endmodule

// File: tb/tb_oven_controller.sv
// Scoreboard bench for oven_controller with a behavioural oven model.
module tb_oven_controller;

    localparam int TickDiv    = 4;
    localparam int Step       = 50;
    localparam int Amb        = 70;
    localparam int TMin       = 300;
    localparam int TMax       = 500;
    localparam int AlarmTicks = 3;

    localparam int PhIdle = 0;
    localparam int PhPre  = 1;
    localparam int PhBake = 2;
    localparam int PhDone = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    oven_controller_if bus ();

    oven_controller #(
        .TICK_DIV    (TickDiv),
        .RAMP_STEP   (Step),
        .AMBIENT     (Amb),
        .TEMP_MIN    (TMin),
        .TEMP_MAX    (TMax),
        .ALARM_TICKS (AlarmTicks)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int cur;
        int left;
        int setp;
        int heat;
        int alrm;
        int st;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural oven: a temperature, a countdown, a setpoint and a phase
    int m_cur   = Amb;
    int m_left  = 0;
    int m_setp  = TMin;
    int m_phase = PhIdle;
    int m_alarm = 0;
    int m_n     = 0;

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic check(input string name, input logic [9:0] act, input int expv);
        n_tests++;
        if (act !== 10'(expv)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model and queue the expected outputs
    task automatic step(input bit rst, input bit on, input bit st, input bit cn,
                        input int tp, input int tm);
        exp_t e;
        bit   tick;
        @(negedge clk);
        reset      = rst;
        bus.onOff  = on;
        bus.start  = st;
        bus.cancel = cn;
        bus.temp   = 10'(tp);
        bus.timer  = 10'(tm);

        tick = ((m_n % TickDiv) == TickDiv - 1);
        if (rst) begin
            m_cur = Amb; m_left = 0; m_setp = TMin; m_phase = PhIdle; m_alarm = 0; m_n = 0;
        end else begin
            m_n++;
            if (m_phase != PhIdle && (!on || cn)) begin
                m_phase = PhIdle;
                m_left  = 0;
            end else if (m_phase == PhIdle) begin
                if (tick) m_cur = imax(Amb, m_cur - Step);
                if (st && on && !cn && tm != 0) begin
                    m_setp  = imin(TMax, imax(TMin, tp));
                    m_left  = tm;
                    m_phase = PhPre;
                end
            end else if (m_phase == PhPre) begin
                if (m_cur >= m_setp) begin
                    m_cur   = m_setp;
                    m_phase = PhBake;
                end else if (tick) begin
                    m_cur = imin(m_setp, m_cur + Step);
                end
            end else if (m_phase == PhBake) begin
                if (tick) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = PhDone;
                        m_alarm = AlarmTicks;
                    end
                end
            end else begin
                if (tick) begin
                    m_alarm--;
                    m_cur = imax(Amb, m_cur - Step);
                    if (m_alarm == 0) m_phase = PhIdle;
                end
            end
        end

        e.cur  = m_cur;
        e.left = m_left;
        e.setp = m_setp;
        e.heat = (m_phase == PhPre || m_phase == PhBake) ? 1 : 0;
        e.alrm = (m_phase == PhDone) ? 1 : 0;
        e.st   = m_phase;
        exp_q.push_back(e);
    endtask

    // Quiet cycle; entry inputs wander to show they are ignored outside a start
    task automatic idle_cycle();
        step(1'b0, 1'b1, 1'b0, 1'b0, int'($urandom_range(0, 1023)),
             int'($urandom_range(0, 1023)));
    endtask

    task automatic run_until(input int phase, input int limit);
        int k;
        k = 0;
        while (m_phase != phase && k < limit) begin
            idle_cycle();
            k++;
        end
        n_tests++;
        if (m_phase != phase) begin
            n_fail++;
            $display("FAIL run_until: phase %0d expected %0d after %0d cycles", m_phase, phase, k);
        end
    endtask

    // Monitor: outputs update every cycle, so compare one queued entry per cycle
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cur_temp", bus.cur_temp, e.cur);
                check("time_left", bus.time_left, e.left);
                check("set_temp", bus.set_temp, e.setp);
                check("heater", {9'd0, bus.heater}, e.heat);
                check("alarm", {9'd0, bus.alarm}, e.alrm);
                check("state_o", {8'd0, bus.state_o}, e.st);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.onOff  = 1'b1;
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        bus.temp   = '0;
        bus.timer  = '0;

        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
        repeat (20) idle_cycle();

        // Full cook: preheat to 350, bake 2 ticks, alarm, back to idle
        step(1'b0, 1'b1, 1'b1, 1'b0, 350, 2);
        run_until(PhBake, 100);
        run_until(PhDone, 100);
        run_until(PhIdle, 100);

        // Setpoint clamping and zero-timer start
        step(1'b0, 1'b1, 1'b1, 1'b0, 900, 1);
        run_until(PhIdle, 200);
        step(1'b0, 1'b1, 1'b1, 1'b0, 100, 1);
        run_until(PhIdle, 200);
        repeat (40) idle_cycle();
        step(1'b0, 1'b1, 1'b1, 1'b0, 400, 0);
        repeat (8) idle_cycle();

        // Cancel mid-preheat once the oven reaches 220
        step(1'b0, 1'b1, 1'b1, 1'b0, 350, 5);
        while (m_phase == PhPre && m_cur < 220) idle_cycle();
        step(1'b0, 1'b1, 1'b0, 1'b1, 350, 5);
        repeat (24) idle_cycle();

        // Start and cancel together in idle
        step(1'b0, 1'b1, 1'b1, 1'b1, 400, 3);
        repeat (4) idle_cycle();

        // Start pulse during bake is ignored
        step(1'b0, 1'b1, 1'b1, 1'b0, 300, 4);
        run_until(PhBake, 100);
        step(1'b0, 1'b1, 1'b1, 1'b0, 450, 9);
        run_until(PhIdle, 200);

        // Power off during bake
        step(1'b0, 1'b1, 1'b1, 1'b0, 300, 4);
        run_until(PhBake, 100);
        idle_cycle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 300, 4);
        step(1'b0, 1'b0, 1'b1, 1'b0, 300, 4);
        repeat (16) idle_cycle();

        // Reset during done
        step(1'b0, 1'b1, 1'b1, 1'b0, 320, 1);
        run_until(PhDone, 100);
        idle_cycle();
        step(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
        repeat (10) idle_cycle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 399) == 0),
                 ($urandom_range(0, 49) != 0),
                 ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 79) == 0),
                 int'($urandom_range(0, 1023)),
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023))
                                             : int'($urandom_range(0, 6)));
        end

        @(posedge clk);
        #3;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/oven_controller.md
Name: oven_controller

Overview:
- Consumer end of the temperature/timer entry path: latches the user setpoint (temp, timer) on a start press and runs the simulated oven.
- Runs preheat ramp, timed bake, done alert and passive cooling. Drives current oven temperature, remaining time, heater and alarm outputs to the display/LED logic.
- Sits between the temperature-entry block and the seven-segment/LED output stage on the board top level.

Parameters:
- TICK_DIV, 50000000, clk cycles per simulated second (one "tick").
- RAMP_STEP, 50, degrees added per tick while heating, or removed per tick while cooling.
- AMBIENT, 70, idle/rest oven temperature.
- TEMP_MIN, 300, lowest accepted setpoint.
- TEMP_MAX, 500, highest accepted setpoint.
- ALARM_TICKS, 3, ticks the alarm stays asserted in DONE.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- onOff  in  1  oven power; low forces IDLE
- start  in  1  one-cycle pulse; begin a cook with current temp/timer
- cancel  in  1  one-cycle pulse; abort cook
- temp  in  10  requested temperature (binary degrees)
- timer  in  10  requested bake time (ticks/seconds)
- cur_temp  out  10  simulated oven temperature
- time_left  out  10  remaining bake ticks
- set_temp  out  10  latched, clamped setpoint
- heater  out  1  heating element on
- alarm  out  1  done alert
- state_o  out  2  current FSM state encoding

Behaviour:
- Reset (sampled on rising clk):
  - state=IDLE, cur_temp=AMBIENT, time_left=0, set_temp=TEMP_MIN, heater=0, alarm=0.
  - Tick counter=0, alarm counter=0.
- Tick generator:
  - Free-running counter 0..TICK_DIV-1; tick=1 for the one cycle where the counter equals TICK_DIV-1, then it wraps to 0.
  - Cleared by reset only. Not cleared by start.
- State encoding: IDLE=0, PREHEAT=1, BAKE=2, DONE=3.
- IDLE:
  - heater=0.
  - On tick: cur_temp=max(AMBIENT, cur_temp-RAMP_STEP).
  - Accepted start (start=1, cancel=0, onOff=1, timer!=0):
    - set_temp=clamp(temp, TEMP_MIN, TEMP_MAX); time_left=timer; next state PREHEAT.
  - start with timer=0 is ignored.
- PREHEAT:
  - heater=1.
  - On tick: cur_temp=min(set_temp, cur_temp+RAMP_STEP).
  - Go to BAKE the cycle after cur_temp==set_temp. If cur_temp>=set_temp on entry, clamp cur_temp=set_temp and go to BAKE on the next cycle.
- BAKE:
  - heater=1; cur_temp holds at set_temp.
  - On tick: time_left decrements.
  - When a tick takes time_left 1->0, next state DONE and the alarm counter loads ALARM_TICKS.
- DONE:
  - heater=0; alarm=1.
  - On tick: the alarm counter decrements and cur_temp cools as in IDLE.
  - When the counter reaches 0, go to IDLE with alarm=0.
- cancel (any non-IDLE state):
  - Next state IDLE; time_left=0; heater=0; alarm=0.
  - cur_temp is retained and cools from its current value.
- onOff=0: same effect as cancel. Start is ignored while onOff=0.
- Simultaneous events:
  - start+cancel in the same cycle: cancel wins, start dropped.
  - start in any non-IDLE state: ignored.
  - temp/timer changes after a start: no effect until the next start.
- Output timing: all outputs registered; a change is visible the cycle after its cause.
- Arithmetic:
  - 10-bit unsigned, saturating.
  - Ramp add is computed 11-bit and compared before truncation, so there is no wrap.
  - Cooling never goes below AMBIENT.
- Reset asserted mid-cook returns every output to its reset value on the next edge.

Decomposition:
- Shared package oven_pkg:
  - state enum (IDLE/PREHEAT/BAKE/DONE).
  - TEMP_MIN, TEMP_MAX and AMBIENT defaults.
  - 10-bit temperature/time typedef.
- One sub-module: tick_gen (parameter TICK_DIV; outputs a one-cycle tick pulse).

Test Plan (TICK_DIV=4, RAMP_STEP=50, AMBIENT=70, ALARM_TICKS=3):
- Reset then idle 20 cycles -> cur_temp=70, heater=0, alarm=0, state_o=0.
- start with temp=350, timer=2:
  - 6 ticks of PREHEAT: 120, 170, …, 350, then clamps at 350.
  - BAKE: time_left 2->1->0.
  - DONE: alarm=1 for 3 ticks, cooling 300, 250, 200.
  - Then IDLE.
- start with temp=900, timer=1 -> set_temp=500. Start with temp=100 -> set_temp=300. Start with timer=0 -> state stays IDLE.
- cancel mid-PREHEAT at cur_temp=220 -> next cycle IDLE, heater=0, time_left=0; cur_temp falls 170, 120, 70, then holds at 70.
- start and cancel on the same cycle in IDLE -> no state change. Start pulse during BAKE -> time_left unaffected.
- Drop onOff during BAKE -> IDLE. Assert reset during DONE -> all outputs return to reset values on the next edge.
